// File: rtl/delay_line_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | delay_line_sequencer: sample-rate sequencer for an external delay line.   |
// | Optional: DELAY_SEQ_UNDERRUN_HOLD_EN repeats the last sample on underrun. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module delay_line_sequencer #(
  parameter int DELAY      = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int DIV        = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         sr_shift,
  output logic                         sr_clear_n,
  output logic [DATA_WIDTH-1:0]        sr_data_in,
  input  logic [DATA_WIDTH-1:0]        sr_data_out,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic                         primed,
  output logic [$clog2(DELAY+1)-1:0]   fill_count,
  output logic                         underrun,
  output logic                         overrun
);

  localparam int CW  = $clog2(DIV);
  localparam int FCW = $clog2(DELAY + 1);
  localparam logic [CW-1:0]  c_slot_cnt = CW'(DIV - 1);
  localparam logic [CW-1:0]  c_cnt_one  = CW'(1);
  localparam logic [FCW-1:0] c_delay    = FCW'(DELAY);
  localparam logic [FCW-1:0] c_one      = FCW'(1);
  localparam logic [FCW-1:0] c_two      = FCW'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [FCW-1:0]        r_fill;
  logic                  r_shift;
  logic                  r_emit;
  logic                  r_clr_n;
  logic [DATA_WIDTH-1:0] r_sr_data;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_underrun;
  logic                  r_overrun;

  logic                  w_slot;
  logic                  w_in_ready;
  logic                  w_take;
  logic                  w_fill_full;
  logic                  w_flush_last;
  logic                  w_clear;
  logic [DATA_WIDTH-1:0] w_gap_data;

  assign w_slot     = (r_cnt == c_slot_cnt);
  assign w_in_ready = w_slot && ((r_state == S_FILL) || (r_state == S_RUN));
  // A slot shifts unless it is the one where enable=0 ends FILL or RUN.
  assign w_take     = w_slot && ((w_in_ready && enable) || (r_state == S_FLUSH));
  assign w_fill_full  = r_shift && (r_state == S_FILL) && ((r_fill + c_one) == c_delay);
  assign w_flush_last = r_shift && (r_state == S_FLUSH) && (r_fill == c_two);

`ifdef DELAY_SEQ_UNDERRUN_HOLD_EN
  logic [DATA_WIDTH-1:0] r_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= '0;
    end else if (r_state == S_IDLE) begin
      r_last <= '0;
    end else if (w_in_ready && in_valid) begin
      r_last <= in_data;
    end
  end

  assign w_gap_data = r_last;
`else
  assign w_gap_data = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (w_slot && !enable) w_state_nxt = S_IDLE;
        else if (w_fill_full)  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_slot && !enable) w_state_nxt = (DELAY > 1) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (w_flush_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Every return to IDLE wipes the line and the fill level.
    if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) w_clear = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_fill     <= '0;
      r_shift    <= 1'b0;
      r_emit     <= 1'b0;
      r_clr_n    <= 1'b1;
      r_sr_data  <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_cnt <= enable ? c_cnt_one : '0;
      else if (w_slot)       r_cnt <= '0;
      else                   r_cnt <= r_cnt + c_cnt_one;

      r_shift <= w_take;
      r_emit  <= w_fill_full || (r_shift && ((r_state == S_RUN) || (r_state == S_FLUSH)));
      r_clr_n <= !w_clear;

      if (w_take) begin
        if (r_state == S_FLUSH) r_sr_data <= '0;
        else if (in_valid)      r_sr_data <= in_data;
        else                    r_sr_data <= w_gap_data;
      end

      if (w_in_ready && !in_valid) r_underrun <= 1'b1;

      if (w_clear) begin
        r_fill <= '0;
      end else if (r_shift) begin
        if (r_state == S_FILL && r_fill != c_delay) r_fill <= r_fill + c_one;
        else if (r_state == S_FLUSH)                r_fill <= r_fill - c_one;
      end
    end
  end

  // Capture wins over a same-cycle handshake; only an unacknowledged overwrite is an overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
    end else if (r_emit) begin
      r_out_data  <= sr_data_out;
      r_out_valid <= 1'b1;
      if (r_out_valid && !out_ready) r_overrun <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign sr_shift   = r_shift;
  assign sr_clear_n = r_clr_n;
  assign sr_data_in = r_sr_data;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign primed     = (r_state == S_RUN);
  assign fill_count = r_fill;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/delay_line_sequencer.md
Name: delay_line_sequencer

Overview:
Controller that sequences a parameterized sample delay line (shift register with shift enable, sync active-low clear) in the pitch-shifter datapath. It divides the system clock down to the audio sample rate and accepts one input sample per sample period through a valid/ready handshake. It drives the delay line's shift strobe and clear, and returns each delayed sample downstream through a valid/ready handshake. It also tracks fill level across a fill/run/flush lifecycle.

Parameters:
DELAY, 1024, delay-line depth in samples (>=1); must match the attached delay line.
DATA_WIDTH, 16, sample width in bits.
DIV, 1024, system clocks per sample period (>=4).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run the delay line, 0 = drain and stop
in_valid  in  1  upstream sample valid
in_data  in  DATA_WIDTH  upstream sample
in_ready  out  1  high only in the sample-slot cycle
sr_shift  out  1  one-cycle shift strobe to the delay line
sr_clear_n  out  1  active-low one-cycle clear to the delay line
sr_data_in  out  DATA_WIDTH  registered sample to the delay line
sr_data_out  in  DATA_WIDTH  delay-line output
out_valid  out  1  delayed sample available
out_data  out  DATA_WIDTH  delayed sample
out_ready  in  1  downstream accepts
primed  out  1  delay line full; outputs are real delayed samples
fill_count  out  clog2(DELAY+1)  samples currently in the line
underrun  out  1  sticky: slot passed with in_valid=0
overrun  out  1  sticky: out_data overwritten before it was accepted

Behaviour:
- Reset values:
  - All outputs 0, except sr_clear_n=1.
  - Tick counter 0. State IDLE.
- Tick counter:
  - Free-runs 0..DIV-1 in FILL, RUN and FLUSH; held at 0 in IDLE.
  - The slot cycle T is when count==DIV-1.
  - in_ready = (state is FILL or RUN) and slot. It is decoded from registers; there is no combinational path from in_valid.
- Slot at T:
  - sr_data_in is loaded at the end of T with in_data if in_valid, else 0 and underrun is set. In FLUSH it is loaded with 0.
  - sr_shift=1 in T+1 only. The delay line updates at the end of T+1.
  - sr_data_out is captured into out_data at the end of T+2 when the emit condition holds; out_valid=1 from T+3.
- Emit condition: after the shift, fill_count==DELAY (RUN), or the state is FLUSH.
- fill_count:
  - +1 per shift in FILL, saturating at DELAY.
  - -1 per shift in FLUSH.
- States:
  - IDLE: enable=1 -> FILL.
  - FILL: the shift that brings fill_count to DELAY -> RUN and primed=1. That shift also emits. enable=0 -> IDLE, with sr_clear_n=0 for one cycle and fill_count=0.
  - RUN: one shift and one emit per slot. enable=0 -> FLUSH if DELAY>1, else IDLE.
  - FLUSH: primed=0. Performs DELAY-1 zero shifts, each emitting. When fill_count reaches 1 -> IDLE, then sr_clear_n pulse and fill_count=0. enable is ignored until IDLE.
- enable is sampled only at the slot cycle in FILL, RUN and FLUSH, and at every cycle in IDLE.
- Output handshake:
  - out_valid clears on out_valid & out_ready.
  - A new capture while out_valid=1 and no handshake in the same cycle: overwrite and set overrun.
  - Capture and handshake in the same cycle: the new data wins, out_valid stays 1, no overrun.
- underrun and overrun clear only on reset.
- Reset mid-operation: all state returns to reset values immediately. The delay line is not cleared by this block on reset; the integrator ties its clear to reset.

Optional Feature:
Macro DELAY_SEQ_UNDERRUN_HOLD_EN.
- Defined: on underrun, the previous accepted sample is repeated into sr_data_in (0 if none since IDLE). underrun is still set.
- Undefined: zero is inserted.

Test Plan:
- DELAY=4, DIV=8; enable=1 at cycle 0, in_valid always 1, in_data=1,2,3,...
  - in_ready at cycles 7,15,23,...; sr_shift at 8,16,....
  - primed after the 4th shift; first out_data=1, out_valid high at cycle 34.
- Same stream, enable=0 while in RUN:
  - Exactly 3 zero shifts, emitting the last 3 real samples in order.
  - Then IDLE, sr_clear_n low for 1 cycle, fill_count=0.
- in_valid=0 at the 2nd slot:
  - Zero inserted (or 1 repeated with HOLD_EN), underrun=1.
  - The corresponding output appears 3 slots later.
- out_ready=0 for 2 slots in RUN: overrun=1; out_data holds the newest sample.
- enable dropped after 2 shifts in FILL: no outputs; sr_clear_n pulse; IDLE; re-enable refills from fill_count=0.
- reset asserted mid-RUN: all outputs 0 and sr_clear_n=1 immediately; state IDLE.
